// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: opcodes, widths, FSM states.
// Optional perf counters in alu_arbiter are enabled by ALU_ARB_PERF_EN.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SHL = 3'b101,
    SHR = 3'b110,
    CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, with wrap.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic          found;
  logic [PW-1:0] k;

  // Walk the requesters starting at ptr; the first valid one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU, flopped on both sides.
// Define ALU_ARB_PERF_EN to add saturating grant/stall counters.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int OP_W    = alu_pkg::OP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [OP_W-1:0]         alu_op,
  output logic [WIDTH-1:0]        alu_r0,
  output logic [WIDTH-1:0]        alu_r1,
  input  logic [WIDTH-1:0]        alu_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]   perf_grants,
  output logic [15:0]             perf_stall
`endif
);

  import alu_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state;
  arb_state_e         state_n;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   data_q;
  logic               accept;
  logic               done;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and handshake outputs; no grant is shown while in reset.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && |gnt) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: state_n = RESP;
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand/result flops, grant holder and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      grant  <= '0;
      rr_ptr <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op[int'(gnt_idx)*OP_W +: OP_W];
        a_q   <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_q   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        grant <= gnt_idx;
      end
      if (state == ISSUE) data_q <= alu_result;
      if (done) begin
        rr_ptr <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);
      end
    end
  end

  assign alu_op   = op_q;
  assign alu_r0   = a_q;
  assign alu_r1   = b_q;
  assign rsp_data = data_q;
  // Qualified by RESP so the flag is low outside a live response.
  assign rsp_zero = (state == RESP) && (data_q == '0);

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;
  logic [15:0]              stall_cnt;

  // Saturating per-requester grant and response-stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && gnt_idx == PW'(i) && grant_cnt[i] != 16'hFFFF) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
      if (state == RESP && !rsp_ready[grant] && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign perf_grants = grant_cnt;
  assign perf_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Perf-counter checks are compiled in only with ALU_ARB_PERF_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*OW-1:0] req_op;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_r0;
  logic [W-1:0]  alu_r1;
  logic [W-1:0]  alu_result;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero;
`ifdef ALU_ARB_PERF_EN
  logic [N*16-1:0] perf_grants;
  logic [15:0]     perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .OP_W(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_r0     (alu_r0),
    .alu_r1     (alu_r1),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  // Behavioural ALU sitting between the two flop stages.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ADD: alu_result = alu_r0 + alu_r1;
      SUB: alu_result = alu_r0 - alu_r1;
      AND: alu_result = alu_r0 & alu_r1;
      OR:  alu_result = alu_r0 | alu_r1;
      XOR: alu_result = alu_r0 ^ alu_r1;
      SHL: alu_result = alu_r0 << 1;
      SHR: alu_result = alu_r0 >> 1;
      CMP: alu_result = (alu_r0 == alu_r1) ? 8'h01 : 8'h00;
      default: alu_result = '0;
    endcase
  end

  task automatic set_req(input int idx, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[idx]      = 1'b1;
    req_op[idx*OW +: OW] = op;
    req_a[idx*W +: W]    = a;
    req_b[idx*W +: W]    = b;
  endtask

  // Stimulus only: one full transaction, returns what the response showed.
  task automatic run_op(input int idx, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input int stall,
                        output logic [7:0] rdata, output logic rzero,
                        output logic [1:0] roh, output bit tmo);
    int cnt;
    tmo = 1'b0;
    rsp_ready = '1;
    if (stall > 0) rsp_ready[idx] = 1'b0;
    set_req(idx, op, a, b);
    cnt = 0;
    @(negedge clk);
    while (req_ready[idx] !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (req_ready[idx] !== 1'b1) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    cnt = 0;
    @(negedge clk);
    while (rsp_valid === 2'b00 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (rsp_valid === 2'b00) tmo = 1'b1;
    rdata = rsp_data;
    rzero = rsp_zero;
    roh   = rsp_valid;
    repeat (stall) @(posedge clk);
    #1;
    rsp_ready = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 2'b00) begin bad++;
      $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++;
      $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    total++; if (alu_op !== 3'b000) begin bad++;
      $display("FAIL reset_alu_op: got %b want 000", alu_op); end
    total++; if (alu_r0 !== 8'h00 || alu_r1 !== 8'h00) begin bad++;
      $display("FAIL reset_alu_r: got %h/%h want 00/00", alu_r0, alu_r1); end
    total++; if (rsp_data !== 8'h00) begin bad++;
      $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    total++; if (rsp_zero !== 1'b0) begin bad++;
      $display("FAIL reset_rsp_zero: got %b want 0", rsp_zero); end
`ifdef ALU_ARB_PERF_EN
    total++; if (perf_grants !== 32'd0 || perf_stall !== 16'd0) begin bad++;
      $display("FAIL reset_perf: got %h/%h want 0/0", perf_grants, perf_stall); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = '1;
    set_req(0, ADD, 8'h05, 8'h03);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++;
      $display("FAIL single_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00) begin bad++;
      $display("FAIL single_issue_valid: got %b want 00", rsp_valid); end
    total++;
    if (alu_op !== 3'b000 || alu_r0 !== 8'h05 || alu_r1 !== 8'h03) begin bad++;
      $display("FAIL single_alu_in: got %b %h %h want 000 05 03",
               alu_op, alu_r0, alu_r1); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01) begin bad++;
      $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    total++; if (rsp_data !== 8'h08 || rsp_zero !== 1'b0) begin bad++;
      $display("FAIL single_rsp_data: got %h z=%b want 08 z=0",
               rsp_data, rsp_zero); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00) begin bad++;
      $display("FAIL single_rsp_drop: got %b want 00", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_oh [4];
    int cnt;
    exp_oh[0] = 2'b01; exp_oh[1] = 2'b10;
    exp_oh[2] = 2'b01; exp_oh[3] = 2'b10;
    reset = 1'b1;
    rsp_ready = '1;
    set_req(0, SUB, 8'h10, 8'h10);
    set_req(1, SUB, 8'h10, 8'h10);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      @(negedge clk);
      while (rsp_valid === 2'b00 && cnt < 8) begin
        @(negedge clk);
        cnt++;
      end
      total++;
      if (rsp_valid !== exp_oh[k] || rsp_data !== 8'h00 || rsp_zero !== 1'b1) begin
        bad++;
        $display("FAIL contention_%0d: got oh=%b d=%h z=%b want oh=%b d=00 z=1",
                 k, rsp_valid, rsp_data, rsp_zero, exp_oh[k]);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    rsp_ready = '1;
    rsp_ready[1] = 1'b0;
    set_req(1, XOR, 8'hF0, 8'h0F);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++;
      $display("FAIL bp_ready1: got %b want 10", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    set_req(0, ADD, 8'h01, 8'h01);
    @(negedge clk);
    total++; if (req_ready !== 2'b00) begin bad++;
      $display("FAIL bp_issue_ready: got %b want 00", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b10 || rsp_data !== 8'hFF) begin bad++;
      $display("FAIL bp_first: got oh=%b d=%h want 10 FF", rsp_valid, rsp_data); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b10 || rsp_data !== 8'hFF || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold_%0d: got oh=%b d=%h rdy=%b want 10 FF 00",
                 c, rsp_valid, rsp_data, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b10) begin bad++;
      $display("FAIL bp_release: got %b want 10", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++;
      $display("FAIL bp_req0_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h02) begin bad++;
      $display("FAIL bp_req0_rsp: got oh=%b d=%h want 01 02", rsp_valid, rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [2:0] ops [3];
    logic [7:0] as  [3];
    logic [7:0] bs  [3];
    logic [7:0] exp [3];
    logic [7:0] d;
    logic       z;
    logic [1:0] oh;
    bit         tmo;
    ops[0] = ADD; as[0] = 8'hFF; bs[0] = 8'h01; exp[0] = 8'h00;
    ops[1] = SHL; as[1] = 8'h81; bs[1] = 8'h5A; exp[1] = 8'h02;
    ops[2] = CMP; as[2] = 8'h2A; bs[2] = 8'h2A; exp[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      run_op(0, ops[k], as[k], bs[k], 0, d, z, oh, tmo);
      total++;
      if (tmo || oh !== 2'b01 || d !== exp[k] || z !== (exp[k] == 8'h00)) begin
        bad++;
        $display("FAIL ops_%0d: got tmo=%0d oh=%b d=%h z=%b want oh=01 d=%h",
                 k, tmo, oh, d, z, exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    rsp_ready = '1;
    set_req(1, SUB, 8'h09, 8'h01);
    @(negedge clk);
    total++; if (req_ready !== 2'b10) begin bad++;
      $display("FAIL rmid_ready: got %b want 10", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || alu_op !== 3'b000 ||
        alu_r0 !== 8'h00 || alu_r1 !== 8'h00 || rsp_data !== 8'h00 ||
        rsp_zero !== 1'b0) begin
      bad++;
      $display("FAIL rmid_zero: got rdy=%b v=%b op=%b r0=%h r1=%h d=%h z=%b want all 0",
               req_ready, rsp_valid, alu_op, alu_r0, alu_r1, rsp_data, rsp_zero);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    total++; if (seen) begin bad++;
      $display("FAIL rmid_no_rsp: got rsp_valid seen=1 want 0"); end
    @(posedge clk); #1;
    set_req(0, ADD, 8'h02, 8'h03);
    set_req(1, ADD, 8'h04, 8'h04);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++;
      $display("FAIL rmid_ptr0: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h05) begin bad++;
      $display("FAIL rmid_after: got oh=%b d=%h want 01 05", rsp_valid, rsp_data); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    logic [7:0] d;
    logic       z;
    logic [1:0] oh;
    bit         tmo;
    bit         any_tmo;
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    @(posedge clk); #1;
    reset = 1'b0;
    any_tmo = 1'b0;
    run_op(0, ADD, 8'h01, 8'h02, 4, d, z, oh, tmo); any_tmo |= tmo;
    run_op(1, ADD, 8'h01, 8'h02, 0, d, z, oh, tmo); any_tmo |= tmo;
    run_op(0, ADD, 8'h01, 8'h02, 0, d, z, oh, tmo); any_tmo |= tmo;
    run_op(1, ADD, 8'h01, 8'h02, 0, d, z, oh, tmo); any_tmo |= tmo;
    run_op(0, ADD, 8'h01, 8'h02, 0, d, z, oh, tmo); any_tmo |= tmo;
    total++; if (any_tmo) begin bad++;
      $display("FAIL perf_timeout: got timeout=1 want 0"); end
    total++; if (perf_grants !== {16'd2, 16'd3}) begin bad++;
      $display("FAIL perf_grants: got %h want 00020003", perf_grants); end
    total++; if (perf_stall !== 16'd4) begin bad++;
      $display("FAIL perf_stall: got %0d want 4", perf_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_ops();
    test_reset_mid();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit combinational ALU between NUM_REQ requesters (e.g. fetch-side address math and the execute stage).
- Round-robin arbitration; one transaction at a time; valid/ready handshake on both request and response sides.
- Registers operands before the ALU and the result after it, so the ALU is isolated between two flop stages.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- WIDTH, 8, operand/result width; must match the ALU.
- OP_W, 3, ALU opcode width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  input  NUM_REQ*OP_W  packed opcodes; requester i at [i*OP_W +: OP_W].
- req_a  input  NUM_REQ*WIDTH  packed operand r0.
- req_b  input  NUM_REQ*WIDTH  packed operand r1.
- alu_op  output  OP_W  to ALU alu_op.
- alu_r0  output  WIDTH  to ALU r0.
- alu_r1  output  WIDTH  to ALU r1.
- alu_result  input  WIDTH  from ALU result.
- rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_data  output  WIDTH  registered ALU result, shared by all requesters.
- rsp_zero  output  1  high when rsp_data == 0.

Behaviour:
- FSM states are IDLE, ISSUE and RESP.
- Reset: state=IDLE, rr_ptr=0, grant=0, op/operand regs=0, rsp_data=0. All outputs are 0 in the cycle after reset is sampled high.
- IDLE:
  - req_ready[g] is combinationally high for the winner g among req_valid, searching from rr_ptr upward with wrap.
  - On that edge: latch op/a/b of g, store grant=g, go to ISSUE.
  - No valid requester: req_ready=0 and the FSM stays in IDLE.
- ISSUE:
  - alu_op/alu_r0/alu_r1 are driven from the latched registers. They are held at those values in every state and change only on acceptance.
  - At the edge, capture alu_result into rsp_data and go to RESP.
- RESP:
  - rsp_valid[grant]=1.
  - When rsp_ready[grant]=1: set rr_ptr=(grant+1) mod NUM_REQ and go to IDLE.
  - While rsp_ready is low: stay in RESP with rsp_data stable. Other requests wait and req_ready stays 0.
- Latency is accept edge + 2 cycles to rsp_valid. Minimum throughput is one op per 3 cycles.
- Requests are accepted only in IDLE. A requester may drop req_valid before acceptance with no effect.
- Simultaneous requests: the lowest index at or above rr_ptr (with wrap) wins. After a grant, the granted requester has lowest priority.
- Width rules: operands and result are WIDTH bits; the ALU defines carry/borrow loss and op semantics. Opcode 3'b111 yields 8'h01 or 8'h00.
- Reset mid-transaction aborts it: no rsp_valid is ever issued for it, and rr_ptr returns to 0.
- NUM_REQ=1 degenerates to a plain 3-cycle pipeline with rr_ptr constant 0.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants (NUM_REQ*16): per-requester saturating grant counters, incremented on each acceptance.
  - Adds output perf_stall (16): a saturating count of RESP cycles with rsp_ready low.
  - All counters clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e enum: ADD=3'b000, SUB, AND, OR, XOR, SHL, SHR, CMP=3'b111.
  - WIDTH and OP_W localparams.
  - arb_state_e enum {IDLE, ISSUE, RESP}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; combinational one-hot gnt[N] plus gnt_idx. alu_arbiter owns the pointer register.

Test Plan:
- Single request: req0 {ADD, 8'h05, 8'h03} -> req_ready[0] in IDLE; rsp_valid[0] two cycles later; rsp_data=8'h08, rsp_zero=0.
- Contention: req0 and req1 both valid continuously from reset, each with {SUB, 8'h10, 8'h10} -> grants alternate 0,1,0,1; every response has rsp_data=8'h00 and rsp_zero=1.
- Back-pressure: rsp_ready[1]=0 for 5 cycles after {XOR, 8'hF0, 8'h0F} -> rsp_valid[1] held and rsp_data=8'hFF stable; req0 not accepted until the response completes.
- Wrap/ops: {ADD, 8'hFF, 8'h01} -> 8'h00; {SHL, 8'h81, x} -> 8'h02; {CMP, 8'h2A, 8'h2A} -> 8'h01.
- Reset mid-op: assert reset in the ISSUE cycle -> no rsp_valid; all outputs 0 the next cycle; the next request is granted from rr_ptr=0.
- With ALU_ARB_PERF_EN: 3 grants to req0, 2 to req1, 4 stall cycles -> perf_grants={16'd2, 16'd3}, perf_stall=16'd4.
